// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU and the issue/writeback sequencer wrapped around it.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: and/or/add/sub selected by ALUControl, modulo 2^WIDTH.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult
);

    always_comb begin
        // NOTE: assign a default first so no path through the case can infer a latch.
        ALUResult = '0;
        case (alu_op_t'(ALUControl))
            ALU_AND: ALUResult = a & b;
            ALU_OR:  ALUResult = a | b;
            ALU_ADD: ALUResult = a + b;
            ALU_SUB: ALUResult = a - b;
            default: ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two operand read ports, a debug read port and one
// synchronous write port. r0 always reads zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem [NREGS];

    // NOTE: the array lives in flops, not RAM, because every register must clear
    // on reset; a RAM macro could not be reset this way.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Two-state issue/writeback stage around an external ALU: latches operands on the
// handshake, writes ALUResult back one edge later and pulses done with fresh flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    parameter  int NREGS = 8,
    parameter  int CNTW  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic             instr_imm_en,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    output logic             done,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic [CNTW-1:0]  retired,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    seq_state_t       state;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;

    // Writeback happens on the EXEC edge, so the next handshake reads the new value.
    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .raddr1   (instr_rs1),
        .raddr2   (instr_rs2),
        .rdata1   (rs1_data),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (state == EXEC),
        .waddr    (rd_q),
        .wdata    (ALUResult)
    );

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_q       <= '0;
            a          <= '0;
            b          <= '0;
            ALUControl <= ALU_AND;
            done       <= 1'b0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
            retired    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        a          <= rs1_data;
                        b          <= instr_imm_en ? instr_imm : rs2_data;
                        ALUControl <= instr_op;
                        rd_q       <= instr_rd;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Flags update even for rd==0, which serves as a compare/test.
                    zero_flag <= (ALUResult == '0);
                    neg_flag  <= ALUResult[WIDTH-1];
                    done      <= 1'b1;
                    retired   <= retired + CNTW'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer + alu: directed scenarios then random traffic.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int CNTW  = 16;
    localparam int SCNTW = 3;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             instr_valid = 1'b0;
    logic [1:0]       instr_op = 2'b00;
    logic [AW-1:0]    instr_rd = '0;
    logic [AW-1:0]    instr_rs1 = '0;
    logic [AW-1:0]    instr_rs2 = '0;
    logic             instr_imm_en = 1'b0;
    logic [WIDTH-1:0] instr_imm = '0;
    logic [AW-1:0]    dbg_addr = '0;

    logic             instr_ready, done, zero_flag, neg_flag;
    logic [WIDTH-1:0] a, b, ALUResult, dbg_data;
    logic [1:0]       ALUControl;
    logic [CNTW-1:0]  retired;

    logic             instr_ready_s, done_s, zero_flag_s, neg_flag_s;
    logic [WIDTH-1:0] a_s, b_s, ALUResult_s, dbg_data_s;
    logic [1:0]       ALUControl_s;
    logic [SCNTW-1:0] retired_s;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm), .a(a), .b(b),
        .ALUControl(ALUControl), .ALUResult(ALUResult), .done(done), .zero_flag(zero_flag),
        .neg_flag(neg_flag), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
    alu #(.WIDTH(WIDTH)) u_alu (.a(a), .b(b), .ALUControl(ALUControl), .ALUResult(ALUResult));

    // Narrow-counter twin on the same instruction bus, so counter wrap is reachable.
    alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS), .CNTW(SCNTW)) dut_s (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready_s),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm), .a(a_s), .b(b_s),
        .ALUControl(ALUControl_s), .ALUResult(ALUResult_s), .done(done_s), .zero_flag(zero_flag_s),
        .neg_flag(neg_flag_s), .retired(retired_s), .dbg_addr(dbg_addr), .dbg_data(dbg_data_s)
    );
    alu #(.WIDTH(WIDTH)) u_alu_s (.a(a_s), .b(b_s), .ALUControl(ALUControl_s), .ALUResult(ALUResult_s));

    typedef struct {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] arch [NREGS];
    logic [WIDTH-1:0] model_rf [NREGS];
    int unsigned      model_retired = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cycle = 0;
    int               last_hs = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [1:0] op, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        int r;
        case (op)
            2'b00:   r = int'(x & y);
            2'b01:   r = int'(x | y);
            2'b10:   r = (int'(x) + int'(y)) % 256;
            default: r = (int'(x) - int'(y) + 256) % 256;
        endcase
        return WIDTH'(r);
    endfunction

    task automatic issue(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                         input logic imm_en, input logic [WIDTH-1:0] imm, input bit b2b);
        logic [WIDTH-1:0] va, vb, r;
        int guard;
        va = (rs1 == 0) ? '0 : arch[rs1];
        vb = imm_en ? imm : ((rs2 == 0) ? '0 : arch[rs2]);
        r  = ref_alu(op, va, vb);
        instr_op = op; instr_rd = AW'(rd); instr_rs1 = AW'(rs1); instr_rs2 = AW'(rs2);
        instr_imm_en = imm_en; instr_imm = imm; instr_valid = 1'b1;
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        if (b2b) check("ready_gap_cycles", 32'(guard), 32'd1);
        @(posedge clk); #1;
        if (b2b) check("throughput", 32'(cycle - last_hs), 32'd2);
        last_hs = cycle;
        check("ready_low_exec", {30'd0, instr_ready, instr_ready_s}, 32'd0);
        sb.push_back('{rd: AW'(rd), val: r, cyc: cycle});
        if (rd != 0) arch[rd] = r;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops on every done pulse, keeps its own view of the regfile and scans dbg.
    initial begin : monitor
        exp_t e;
        int   scan;
        scan = 0;
        for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
                for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
                model_retired = 0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'(done), 32'd0);
                        dbg_addr = AW'(scan);
                    end else begin
                        e = sb.pop_front();
                        if (e.rd != '0) model_rf[e.rd] = e.val;
                        model_retired++;
                        check("done_latency", 32'(cycle - e.cyc), 32'd1);
                        check("zero_flag", 32'(zero_flag), 32'(e.val == '0));
                        check("neg_flag", 32'(neg_flag), 32'(e.val[WIDTH-1]));
                        check("retired", 32'(retired), model_retired % 32'h10000);
                        check("done_s", 32'(done_s), 32'd1);
                        check("zero_flag_s", 32'(zero_flag_s), 32'(e.val == '0));
                        check("neg_flag_s", 32'(neg_flag_s), 32'(e.val[WIDTH-1]));
                        check("retired_s_wrap", 32'(retired_s), model_retired % 8);
                        dbg_addr = e.rd;
                    end
                end else begin
                    dbg_addr = AW'(scan);
                end
                scan = (scan + 1) % NREGS;
                #1;
                check("dbg_data", 32'(dbg_data), 32'(model_rf[dbg_addr]));
                check("dbg_data_s", 32'(dbg_data_s), 32'(model_rf[dbg_addr]));
            end
        end
    end

    initial begin : stimulus
        int guard;
        for (int i = 0; i < NREGS; i++) arch[i] = '0;

        // Reset state while reset_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_ctl", 32'(ALUControl), 32'd0);
        check("rst_flags", {30'd0, zero_flag, neg_flag}, 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        idle(NREGS + 1);

        // Immediate loads and an add.
        issue(ALU_ADD, 1, 0, 0, 1'b1, 8'h05, 1'b0);
        issue(ALU_ADD, 2, 0, 0, 1'b1, 8'h03, 1'b1);
        issue(ALU_ADD, 3, 1, 2, 1'b0, 8'h00, 1'b1);
        idle(3);
        check("retired_after_3", 32'(retired), 32'd3);

        // Subtraction to zero and to negative.
        issue(ALU_SUB, 4, 1, 1, 1'b0, 8'h00, 1'b0);
        issue(ALU_SUB, 5, 2, 1, 1'b0, 8'h00, 1'b1);

        // Logic ops and r0 as a discard destination.
        issue(ALU_ADD, 1, 0, 0, 1'b1, 8'hF0, 1'b1);
        issue(ALU_ADD, 2, 0, 0, 1'b1, 8'h3C, 1'b1);
        issue(ALU_AND, 6, 1, 2, 1'b0, 8'h00, 1'b1);
        issue(ALU_OR,  7, 1, 2, 1'b0, 8'h00, 1'b1);
        issue(ALU_ADD, 0, 1, 2, 1'b0, 8'h00, 1'b1);

        // Dependent chain r1 = r1 + r1 from r1 = 1, back to back.
        issue(ALU_ADD, 1, 0, 0, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 3; i++) issue(ALU_ADD, 1, 1, 1, 1'b0, 8'h00, 1'b1);
        idle(3);
        check("chain_r1", 32'(arch[1]), 32'h08);

        // Reset during EXEC discards the instruction.
        issue(ALU_ADD, 3, 1, 2, 1'b0, 8'h00, 1'b0);
        instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(instr_ready), 32'd1);
        check("midrst_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        check("midrst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) arch[i] = '0;
        idle(NREGS + 1);
        check("postrst_retired", 32'(retired), 32'd0);

        // Random traffic with random gaps.
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 1) idle(gap - 1);
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  gap <= 1);
        end
        instr_valid = 1'b0;

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        idle(NREGS + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/writeback stage wrapped around the existing 8-bit ALU (and/or/add/sub selected by a 2-bit ALUControl).
- Accepts one register-to-register or register-immediate instruction per valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's a, b and ALUControl inputs, samples ALUResult, and writes it back to the register file with Zero/Negative flags.
- The ALU stays a separate instance; this block connects to its ports.

Parameters:
WIDTH, 8, datapath width; must match the ALU width
NREGS, 8, register file depth; power of two; r0 is hardwired to zero
CNTW, 16, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction
instr_op  input  2  ALU op: 00 and, 01 or, 10 add, 11 sub
instr_rd  input  log2(NREGS)  destination register
instr_rs1  input  log2(NREGS)  source register for a
instr_rs2  input  log2(NREGS)  source register for b when imm_en=0
instr_imm_en  input  1  1: b = instr_imm
instr_imm  input  WIDTH  immediate operand
a  output  WIDTH  to ALU a, registered
b  output  WIDTH  to ALU b, registered
ALUControl  output  2  to ALU ALUControl, registered
ALUResult  input  WIDTH  from ALU; combinational function of a, b, ALUControl
done  output  1  one-cycle pulse when writeback is visible
zero_flag  output  1  last result == 0, registered
neg_flag  output  1  last result bit WIDTH-1, registered
retired  output  CNTW  count of completed instructions; wraps
dbg_addr  input  log2(NREGS)  debug read address
dbg_data  output  WIDTH  combinational read of regfile[dbg_addr]; r0 reads 0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state IDLE; all registers 0.
  - a, b, ALUControl, done, zero_flag, neg_flag, retired = 0.
  - Takes effect immediately, mid-instruction included. An in-flight instruction is discarded: no writeback, no done, no counter increment.
- FSM states: IDLE, EXEC.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, on the rising edge:
    - a <= reg[rs1].
    - b <= imm_en ? imm : reg[rs2].
    - ALUControl <= op.
    - latch rd.
    - go to EXEC.
  - Without valid, stay IDLE; a, b and ALUControl hold their last values.
- EXEC:
  - instr_ready=0; a, b and ALUControl are stable for the whole cycle.
  - On the rising edge:
    - reg[rd] <= ALUResult, unless rd==0.
    - zero_flag <= (ALUResult==0).
    - neg_flag <= ALUResult[WIDTH-1].
    - done <= 1; retired <= retired+1.
    - go to IDLE.
  - Flags update even when rd==0, which gives a compare/test idiom.
- done is high exactly one cycle: the first IDLE cycle after EXEC. It is cleared on the next edge unless another EXEC completes.
- Timing:
  - Handshake at edge N, result written at edge N+1, done high during cycle N+1→N+2.
  - Throughput is 1 instruction per 2 cycles.
  - A new handshake during the done cycle is legal.
- Hazards:
  - The write at edge N+1 is complete before any subsequent handshake reads the register file, so no bypass is needed.
  - rs1==rd and rs2==rd read the old value.
- r0:
  - Reads return 0 on all paths (operands, dbg_data).
  - Writes are dropped.
- Arithmetic: entirely the ALU's; modulo 2^WIDTH; no carry/overflow captured.
- retired wraps from 2^CNTW-1 to 0 silently.
- instr_valid while instr_ready=0 is ignored; the driver must hold it. No instruction fields are sampled outside the handshake edge.
- dbg_data is combinational and reflects a write from the following cycle onward.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t (enum: ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11);
  - typedef seq_state_t (IDLE, EXEC);
  - localparam default WIDTH.
- The ALU uses the same enum.
- One natural sub-module: alu_regfile:
  - NREGS x WIDTH;
  - two combinational read ports plus debug read;
  - one synchronous write port;
  - r0 hardwired to zero;
  - asynchronous active-low clear.
- The FSM and flag/counter logic stay in alu_op_sequencer.
- The testbench instantiates alu_op_sequencer and alu and connects them.

Test Plan:
- Reset then idle:
  - reset_n=0 for 2 cycles → a=b=0, ALUControl=00, flags 0, retired=0, instr_ready=1.
  - dbg_data=0 for every address.
- Immediate load then add:
  - Load r1: op=10, rd=1, rs1=0, imm_en=1, imm=8'h05 → one cycle later done=1, dbg(1)=8'h05.
  - Load r2: op=10, rd=2, rs1=0, imm_en=1, imm=8'h03.
  - Add: op=10, rd=3, rs1=1, rs2=2 → dbg(3)=8'h08, zero=0, neg=0, retired=3.
- Sub to zero and negative:
  - Sub with rd=4, rs1=1, rs2=1 → dbg(4)=0, zero_flag=1.
  - Sub with rd=5, rs1=2, rs2=1 → dbg(5)=8'hFE, neg_flag=1, zero_flag=0.
- Logic ops and r0:
  - r1=8'hF0, r2=8'h3C.
  - and to rd=6 → 8'h30; or to rd=7 → 8'hFC.
  - add to rd=0 → dbg(0) stays 0, flags still update, retired increments.
- Handshake:
  - instr_valid held continuously across back-to-back instructions → instr_ready toggles 1,0,1,0.
  - Exactly one instruction accepted per 2 cycles.
  - Dependent chain: r1=r1+r1, three times from r1=1 → r1=8'h08.
- Reset mid-op:
  - Assert reset_n=0 during EXEC of add rd=3 → no write, done stays 0, retired=0, state IDLE.
  - Separately, force retired to 16'hFFFF and retire one instruction → retired=0.
